grid_nav_ctrl: RTL

- Parametrised player-position controller for the tile-grid game.
- Takes a keypad code plus a move strobe and performs at most one move per strobe rising edge.
- Supports optional wrap-around at grid edges, and checks the target cell against an external wall/obstacle map (synchronous ROM) before committing.
- Drives the linear tile address consumed by the room/display ROMs, plus status pulses for the sound and score logic.

---
 rtl/grid_pkg.sv | 24 ++
 rtl/grid_nav_ctrl_strobe_sync_edge.sv | 23 ++
 rtl/grid_nav_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared keypad/navigation types: key codes, move directions and controller FSM states.
// Pure declarations, no logic, so no latency or backpressure applies.
package grid_pkg;

    localparam logic [3:0] KEY_UP    = 4'h2;
    localparam logic [3:0] KEY_DOWN  = 4'h8;
    localparam logic [3:0] KEY_LEFT  = 4'h4;
    localparam logic [3:0] KEY_RIGHT = 4'h6;

    typedef enum logic [2:0] {UP, DOWN, RIGHT, LEFT, NONE} dir_t;

    typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_PROBE, ST_DECIDE} state_t;

    function automatic dir_t key_to_dir(input logic [3:0] key);
        case (key)
            KEY_UP:    return UP;
            KEY_DOWN:  return DOWN;
            KEY_LEFT:  return LEFT;
            KEY_RIGHT: return RIGHT;
            default:   return NONE;
        endcase
    endfunction

endpackage

// File: rtl/grid_nav_ctrl_strobe_sync_edge.sv
// 2-FF synchroniser plus rising-edge detector for an asynchronous strobe.
// Pulse appears 2 clocks after the pin is first sampled high and lasts one clock; no backpressure.
module strobe_sync_edge (
    input  logic clk_50MHz_i,
    input  logic rst_sync_la_i,
    input  logic strobe_async,
    output logic rise_pulse
);

    // [0],[1] synchronise; [2] holds the previous synchronised level for edge detection
    logic [2:0] sync_q;

    always_ff @(posedge clk_50MHz_i) begin
        if (!rst_sync_la_i) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], strobe_async};
        end
    end

    assign rise_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/grid_nav_ctrl.sv
// Player position controller: one keypad move per strobe edge, with edge wrap and wall-map check.
// Accepted edge to moved_o/bump_o takes 2+MAP_LAT clocks; strobe edges arriving while busy_o is high are dropped.
module grid_nav_ctrl
    import grid_pkg::*;
#(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 4,
    parameter int START_X = 7,
    parameter int START_Y = 3,
    parameter int MAP_LAT = 1,
    localparam int XB = $clog2(GRID_W),
    localparam int YB = $clog2(GRID_H),
    localparam int AW = XB + YB
) (
    input  logic          clk_50MHz_i,
    input  logic          rst_sync_la_i,
    input  logic [3:0]    key_i,
    input  logic          enable_move_i,
    input  logic          wrap_en_i,
    output logic [AW-1:0] probe_addr_o,
    input  logic          probe_blocked_i,
    output logic [AW-1:0] address_o,
    output logic          moved_o,
    output logic          bump_o,
    output logic          busy_o
);

    localparam logic [XB-1:0] X_MAX = XB'(GRID_W - 1);
    localparam logic [YB-1:0] Y_MAX = YB'(GRID_H - 1);

    state_t        state;
    dir_t          dir_q;
    logic          wrap_q;
    logic [XB-1:0] posx;
    logic [YB-1:0] posy;
    logic [1:0]    lat_cnt;
    logic          req;

    logic [XB-1:0] tx;
    logic [YB-1:0] ty;
    logic          at_edge;
    logic          has_dir;

    strobe_sync_edge u_strobe (
        .clk_50MHz_i  (clk_50MHz_i),
        .rst_sync_la_i(rst_sync_la_i),
        .strobe_async (enable_move_i),
        .rise_pulse   (req)
    );

    assign address_o = {posy, posx};

    // Edge tests compare against the true grid limits so non-power-of-2 sizes wrap correctly
    always_comb begin
        tx      = posx;
        ty      = posy;
        at_edge = 1'b0;
        has_dir = 1'b1;
        case (dir_q)
            UP: begin
                if (posy == '0) begin
                    at_edge = 1'b1;
                    ty      = Y_MAX;
                end else begin
                    ty = posy - YB'(1);
                end
            end
            DOWN: begin
                if (posy == Y_MAX) begin
                    at_edge = 1'b1;
                    ty      = '0;
                end else begin
                    ty = posy + YB'(1);
                end
            end
            LEFT: begin
                if (posx == '0) begin
                    at_edge = 1'b1;
                    tx      = X_MAX;
                end else begin
                    tx = posx - XB'(1);
                end
            end
            RIGHT: begin
                if (posx == X_MAX) begin
                    at_edge = 1'b1;
                    tx      = '0;
                end else begin
                    tx = posx + XB'(1);
                end
            end
            default: has_dir = 1'b0;
        endcase
    end

    always_ff @(posedge clk_50MHz_i) begin
        if (!rst_sync_la_i) begin
            state        <= ST_IDLE;
            dir_q        <= NONE;
            wrap_q       <= 1'b0;
            posx         <= XB'(START_X);
            posy         <= YB'(START_Y);
            probe_addr_o <= {YB'(START_Y), XB'(START_X)};
            lat_cnt      <= 2'd0;
            moved_o      <= 1'b0;
            bump_o       <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            moved_o <= 1'b0;
            bump_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        dir_q  <= key_to_dir(key_i);
                        wrap_q <= wrap_en_i;
                        state  <= ST_EVAL;
                        busy_o <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (!has_dir) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else if (at_edge && !wrap_q) begin
                        bump_o <= 1'b1;
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        probe_addr_o <= {ty, tx};
                        lat_cnt      <= 2'(MAP_LAT);
                        state        <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    lat_cnt <= lat_cnt - 2'd1;
                    if (lat_cnt == 2'd1) begin
                        state <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    // probe_addr_o still holds the target, and becomes the position on a clear cell
                    if (probe_blocked_i) begin
                        bump_o       <= 1'b1;
                        probe_addr_o <= {posy, posx};
                    end else begin
                        {posy, posx} <= probe_addr_o;
                        moved_o      <= 1'b1;
                    end
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
